// File: rtl/serial_add3.sv
// Bit-serial three-operand adder: accepts x/y/z over a valid/ready handshake,
// adds them LSB first one bit per clock, and returns the (WIDTH+2)-bit sum {co, sum}.
module serial_add3 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [1:0]       co
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] xs, ys, zs, acc;
  logic [1:0]       carry;
  logic [CW-1:0]    count;
  logic [2:0]       t;
  logic             last;

  // Per-bit column sum: three operand bits plus a carry of up to 2 gives 0..5.
  assign t    = 3'(xs[0]) + 3'(ys[0]) + 3'(zs[0]) + 3'(carry);
  assign last = (count == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = ADD;
      ADD:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // NOTE: the operand and partial-sum shift registers are not reset; they are
  // always loaded on accept and fully shifted through before being observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      co    <= '0;
      carry <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xs    <= x;
            ys    <= y;
            zs    <= z;
            carry <= '0;
            count <= '0;
          end
        end
        ADD: begin
          acc   <= {t[0], acc[WIDTH-1:1]};
          xs    <= xs >> 1;
          ys    <= ys >> 1;
          zs    <= zs >> 1;
          carry <= t[2:1];
          count <= count + CW'(1);
          // sum/co are only updated on completion, so they hold the previous
          // result while a new operation is in flight.
          if (last) begin
            sum <= {t[0], acc[WIDTH-1:1]};
            co  <= t[2:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add3.sv
// Directed and randomized self-checking bench for serial_add3 (WIDTH = 4).
module tb_serial_add3;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x, y, z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [1:0]       co;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_n  = 0;
  int acc_cyc[$];
  logic [WIDTH+1:0] res_q[$];

  serial_add3 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle; events take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready === 1'b1 && out_valid === 1'b1) begin
        errors++;
        $display("FAIL ready_valid_overlap: in_ready=%b out_valid=%b, required never both 1",
                 in_ready, out_valid);
      end
      if (in_valid && in_ready) begin
        acc_n++;
        acc_cyc.push_back(cyc + 1);
      end
      if (out_valid && out_ready) res_q.push_back({co, sum});
    end
  end

  task automatic send_op(input logic [WIDTH-1:0] a, b, c);
    int n0;
    n0 = acc_n;
    x = a; y = b; z = c; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_n > n0) break;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_n == n0) begin
      errors++;
      $display("FAIL accept_timeout: accepts=%0d, required %0d", acc_n, n0 + 1);
    end
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 40 && res_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; z = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 4'b0000 || co !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%b co=%b, required 1 0 0000 00",
               in_ready, out_valid, sum, co);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n0;
    n0 = acc_n;
    res_q.delete();
    x = 4'd1; y = 4'd1; z = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (acc_n !== n0 + 1) begin
      errors++;
      $display("FAIL basic_accept: accepts=%0d, required %0d", acc_n, n0 + 1);
    end
    // After accept edge k, observe state after edges k..k+4.
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== (j == 4)) begin
        errors++;
        $display("FAIL basic_latency[%0d]: in_ready=%b out_valid=%b, required 0 %b",
                 j, in_ready, out_valid, (j == 4));
      end
    end
    checks++;
    if (sum !== 4'b0010 || co !== 2'b00) begin
      errors++;
      $display("FAIL basic_result: sum=%b co=%b, required 0010 00", sum, co);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_q.size() != 1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b results=%0d, required 0 1 1",
               out_valid, in_ready, res_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = acc_n;
    res_q.delete();
    acc_cyc.delete();
    out_ready = 1'b1;
    x = 4'd5; y = 4'd1; z = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 40 && acc_n < n0 + 2; i++) begin
      @(posedge clk); #1;
      if (acc_n == n0 + 1) begin x = 4'd7; y = 4'd2; z = 4'd1; end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_n != n0 + 2 || acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_accepts: accepts=%0d, required 2", acc_n - n0);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != WIDTH + 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, required %0d",
                 acc_cyc[1] - acc_cyc[0], WIDTH + 2);
      end
    end
    wait_results(2);
    checks++;
    if (res_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: results=%0d, required 2", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 6'b00_0111 || res_q[1] !== 6'b00_1010) begin
        errors++;
        $display("FAIL b2b_values: got %b %b, required 000111 001010", res_q[0], res_q[1]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_max_carry();
    logic [WIDTH-1:0] va[2] = '{4'd15, 4'd15};
    logic [WIDTH-1:0] vb[2] = '{4'd15, 4'd1};
    logic [WIDTH-1:0] vc[2] = '{4'd15, 4'd0};
    logic [WIDTH+1:0] ve[2] = '{6'b10_1101, 6'b01_0000};
    for (int i = 0; i < 2; i++) begin
      res_q.delete();
      out_ready = 1'b1;
      send_op(va[i], vb[i], vc[i]);
      wait_results(1);
      checks++;
      if (res_q.size() != 1 || sum !== ve[i][3:0] || co !== ve[i][5:4] || res_q[0] !== ve[i]) begin
        errors++;
        $display("FAIL max_carry[%0d]: results=%0d sum=%b co=%b, required 1 %b %b",
                 i, res_q.size(), sum, co, ve[i][3:0], ve[i][5:4]);
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    res_q.delete();
    out_ready = 1'b0;
    send_op(4'd15, 4'd5, 4'd0);
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || sum !== 4'b0100 || co !== 2'b01 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: out_valid=%b sum=%b co=%b in_ready=%b, required 1 0100 01 0",
                 i, out_valid, sum, co, in_ready);
      end
      in_valid = i[0];
      x = 4'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    x = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_q.size() != 1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b results=%0d, required 0 1 1",
               out_valid, in_ready, res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 6'b01_0100) begin
        errors++;
        $display("FAIL backpressure_value: got %b, required 010100", res_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_q.delete();
    out_ready = 1'b1;
    send_op(4'd9, 4'd9, 4'd9);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== 4'b0000 || co !== 2'b00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b sum=%b co=%b in_ready=%b, required 0 0000 00 1",
               out_valid, sum, co, in_ready);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_leak: results=%0d, required 0", res_q.size());
    end
    send_op(4'd0, 4'd1, 4'd2);
    wait_results(1);
    checks++;
    if (res_q.size() != 1 || res_q[0] !== 6'b00_0011) begin
      errors++;
      $display("FAIL reset_mid_fresh: results=%0d sum=%b co=%b, required 1 0011 00",
               res_q.size(), sum, co);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [WIDTH+1:0] exp_q[$];
    int seen, sent;
    res_q.delete();
    seen = acc_n;
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 40000 && res_q.size() < N; c++) begin
      if (acc_n > seen) begin seen = acc_n; in_valid = 1'b0; end
      if (!in_valid && sent < N) begin
        x = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, 15));
        z = 4'($urandom_range(0, 15));
        exp_q.push_back(6'(x) + 6'(y) + 6'(z));
        in_valid = 1'b1;
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (res_q.size() != N) begin
      errors++;
      $display("FAIL random_count: results=%0d, required %0d", res_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (res_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random[%0d]: got %0d, required %0d", i, res_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max_carry();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
